leddc_pwm_core: RTL and testbench

Parametrised single-clock grayscale PWM engine for the LED display controller family. It holds two banks of per-scanline, per-channel grayscale words. The bank pair is either active (driving PWM) or shadow (being loaded), and the roles swap on request at frame boundaries. During each Vsync-framed scanline period it drives CH channel outputs so that every channel is high for exactly its grayscale value in GCK cycles. Conventional or scrambled PWM ordering is selectable at run time. It sits after the serial data deserialiser and before the LED current-sink pads.

---
 rtl/leddc_pwm_core.sv | 149 ++++++++++++++
 tb/tb_leddc_pwm_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leddc_pwm_core.sv
// leddc_pwm_core -- double-banked grayscale PWM engine for the LED display
// controller family.
//
// Two banks hold one grayscale word per (scanline, channel). One bank is
// active and drives the PWM compare, and the other (shadow) is loaded through
// the write port. The roles exchange only at a frame boundary, after a swap
// request. Each scanline period is 2^GS_W Vsync-high GCK edges long. During
// that period every channel is high for exactly its grayscale value.
//
// Build option: LEDDC_SCRAMBLE_EN
//   defined   -> mode selects conventional (0) or scrambled (1) ordering
//   undefined -> conventional ordering only; mode and SEG_W are unused
//
// Ports
//   GCK        clock, rising edge
//   rst_n      async active-low reset; clears all state and both banks
//   wr_en      write wr_data into shadow bank at (wr_line, wr_ch)
//   wr_line    scanline index of write
//   wr_ch      channel index of write
//   wr_data    grayscale word
//   swap       one-cycle request to exchange banks at the next frame wrap
//   Vsync      1 = period running, 0 = blank (OUT=0, counter cleared)
//   mode       0 = conventional, 1 = scrambled ordering
//   OUT        registered channel drive
//   line       scanline currently driven
//   frame_done one-cycle pulse on the edge where line wraps to 0
//   swap_pend  swap request latched but not yet applied

// Per-channel compare and output register.
module leddc_pwm_lane #(
  parameter int GS_W  = 16,
  parameter int SEG_W = 6
) (
  input  logic            GCK,
  input  logic            rst_n,
  input  logic            vsync,
  input  logic            mode,
  input  logic [GS_W-1:0] cnt,
  input  logic [GS_W-1:0] gs,
  output logic            out
);
  logic hit;

`ifdef LEDDC_SCRAMBLE_EN
  localparam int SUB_W = GS_W - SEG_W;

  // cnt = {seg, sub}, gs = {hi, lo}: every segment gets hi cycles.
  // The first lo segments get one extra cycle each.
  logic [SEG_W-1:0] seg, lo;
  logic [SUB_W-1:0] sub, hi;

  assign seg = cnt[GS_W-1 -: SEG_W];
  assign sub = cnt[SUB_W-1:0];
  assign hi  = gs[GS_W-1 -: SUB_W];
  assign lo  = gs[SEG_W-1:0];
  assign hit = mode ? ((sub < hi) || ((sub == hi) && (seg < lo))) : (cnt < gs);
`else
  localparam int unused_seg_w = SEG_W;
  logic unused_mode;
  assign unused_mode = mode;
  assign hit = (cnt < gs);
`endif

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= vsync & hit;
  end
endmodule

module leddc_pwm_core #(
  parameter int CH    = 16,
  parameter int GS_W  = 16,
  parameter int SCAN  = 32,
  parameter int SEG_W = 6,
  parameter int LW    = $clog2(SCAN),
  parameter int CW    = $clog2(CH)
) (
  input  logic            GCK,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [LW-1:0]   wr_line,
  input  logic [CW-1:0]   wr_ch,
  input  logic [GS_W-1:0] wr_data,
  input  logic            swap,
  input  logic            Vsync,
  input  logic            mode,
  output logic [CH-1:0]   OUT,
  output logic [LW-1:0]   line,
  output logic            frame_done,
  output logic            swap_pend
);
  typedef struct packed {
    logic            en;
    logic [LW-1:0]   line;
    logic [CW-1:0]   ch;
    logic [GS_W-1:0] data;
  } wr_req_t;

  wr_req_t                               wr;
  logic [1:0][SCAN-1:0][CH-1:0][GS_W-1:0] bank;
  logic [CH-1:0][GS_W-1:0]                gs_line;
  logic                                   sel;
  logic [GS_W-1:0]                        cnt;
  logic                                   period_end, frame_end;

  assign wr         = '{en: wr_en, line: wr_line, ch: wr_ch, data: wr_data};
  assign gs_line    = bank[sel][line];
  assign period_end = Vsync && (cnt == '1);
  assign frame_end  = period_end && (line == LW'(SCAN - 1));

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      bank       <= '0;
      sel        <= 1'b0;
      swap_pend  <= 1'b0;
      cnt        <= '0;
      line       <= '0;
      frame_done <= 1'b0;
    end else begin
      // Uses pre-edge sel, so a write on the swap edge lands in the bank
      // that becomes active on that edge.
      if (wr.en) bank[!sel][wr.line][wr.ch] <= wr.data;

      // Blanking clears the counter, so an interrupted line restarts in full.
      cnt        <= Vsync ? cnt + 1'b1 : '0;
      frame_done <= frame_end;

      if (period_end) line <= frame_end ? '0 : line + 1'b1;
      if (frame_end && swap_pend) sel <= !sel;

      // A request arriving on the wrap edge itself stays pending for the
      // next wrap.
      if (swap)           swap_pend <= 1'b1;
      else if (frame_end) swap_pend <= 1'b0;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    leddc_pwm_lane #(.GS_W(GS_W), .SEG_W(SEG_W)) u_lane (
      .GCK   (GCK),
      .rst_n (rst_n),
      .vsync (Vsync),
      .mode  (mode),
      .cnt   (cnt),
      .gs    (gs_line[k]),
      .out   (OUT[k])
    );
  end
endmodule

// File: tb/tb_leddc_pwm_core.sv
// Directed bench for leddc_pwm_core on a reduced geometry:
// 4 channels, 8-bit grayscale (256-cycle line), 4 lines per frame, and
// 3-bit segment index.
module tb_leddc_pwm_core;
  localparam int CH     = 4;
  localparam int GS_W   = 8;
  localparam int SCAN   = 4;
  localparam int SEG_W  = 3;
  localparam int LW     = $clog2(SCAN);
  localparam int CW     = $clog2(CH);
  localparam int PERIOD = 1 << GS_W;
  localparam int FRAME  = PERIOD * SCAN;
  localparam int SEGLEN = 1 << (GS_W - SEG_W);

  logic            GCK = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [LW-1:0]   wr_line;
  logic [CW-1:0]   wr_ch;
  logic [GS_W-1:0] wr_data;
  logic            swap, Vsync, mode;
  logic [CH-1:0]   OUT;
  logic [LW-1:0]   line;
  logic            frame_done, swap_pend;

  leddc_pwm_core #(.CH(CH), .GS_W(GS_W), .SCAN(SCAN), .SEG_W(SEG_W)) dut (
    .GCK(GCK), .rst_n(rst_n), .wr_en(wr_en), .wr_line(wr_line), .wr_ch(wr_ch),
    .wr_data(wr_data), .swap(swap), .Vsync(Vsync), .mode(mode), .OUT(OUT),
    .line(line), .frame_done(frame_done), .swap_pend(swap_pend)
  );

  always #5 GCK = ~GCK;

  typedef struct {
    int line;
    int ch;
    int gs;
    int exp;
  } vec_t;

  vec_t tbl[16];
  int   mdl[2][SCAN][CH];
  int   cnts[SCAN][CH];
  int   act;
  int   fd_cnt, fd_idx, seg0_hits;
  int   n_tests, n_fail;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int l = 0; l < SCAN; l++)
      for (int c = 0; c < CH; c++) cnts[l][c] = 0;
    fd_cnt = 0; fd_idx = -1; seg0_hits = 0;
  endtask

  // Advance n edges and credit each OUT sample to the line driven at that edge.
  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      int l;
      l = int'(line);
      @(posedge GCK); #1;
      for (int c = 0; c < CH; c++) if (OUT[c]) cnts[l][c]++;
      if (frame_done) begin fd_cnt++; fd_idx = k; end
      if (l == 1 && (k % PERIOD) < SEGLEN && OUT[0]) seg0_hits++;
    end
  endtask

  task automatic run_frame();
    clear_counts();
    Vsync = 1'b1;
    run_edges(FRAME);
    Vsync = 1'b0;
  endtask

  task automatic put(input int l, input int c, input int v);
    wr_en = 1'b1; wr_line = LW'(l); wr_ch = CW'(c); wr_data = GS_W'(v);
    mdl[1-act][l][c] = v;
    @(posedge GCK); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_frame(input string name, input int b);
    for (int l = 0; l < SCAN; l++)
      for (int c = 0; c < CH; c++)
        check($sformatf("%s l%0d c%0d", name, l, c), cnts[l][c], mdl[b][l][c]);
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    @(posedge GCK); #1;
    swap = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; act = 0;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < SCAN; l++)
        for (int c = 0; c < CH; c++) mdl[b][l][c] = 0;

    tbl[0]  = '{0, 0, 8'h00,   0}; tbl[1]  = '{0, 1, 8'h01,   1};
    tbl[2]  = '{0, 2, 8'h7F, 127}; tbl[3]  = '{0, 3, 8'hFF, 255};
    tbl[4]  = '{1, 0, 8'h09,   9}; tbl[5]  = '{1, 1, 8'h20,  32};
    tbl[6]  = '{1, 2, 8'h80, 128}; tbl[7]  = '{1, 3, 8'hFE, 254};
    tbl[8]  = '{2, 0, 8'h40,  64}; tbl[9]  = '{2, 1, 8'h11,  17};
    tbl[10] = '{2, 2, 8'hC3, 195}; tbl[11] = '{2, 3, 8'h05,   5};
    tbl[12] = '{3, 0, 8'h3C,  60}; tbl[13] = '{3, 1, 8'h02,   2};
    tbl[14] = '{3, 2, 8'hA0, 160}; tbl[15] = '{3, 3, 8'h71, 113};

    rst_n = 1'b0; wr_en = 1'b0; wr_line = '0; wr_ch = '0; wr_data = '0;
    swap = 1'b0; Vsync = 1'b0; mode = 1'b0;
    #2;
    check("reset OUT", int'(OUT), 0);
    check("reset line", int'(line), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset swap_pend", int'(swap_pend), 0);
    #10 rst_n = 1'b1;
    @(posedge GCK); #1;

    // Load shadow, request swap: first frame still shows the zeroed bank.
    for (int i = 0; i < 16; i++) put(tbl[i].line, tbl[i].ch, tbl[i].gs);
    pulse_swap();
    check("swap_pend set", int'(swap_pend), 1);
    run_frame();
    check_frame("pre-swap frame", act);
    check("frame_done pulses", fd_cnt, 1);
    check("frame_done at wrap edge", fd_idx, FRAME - 1);
    check("swap_pend cleared", int'(swap_pend), 0);
    act = 1 - act;
    run_frame();
    for (int i = 0; i < 16; i++)
      check($sformatf("table l%0d c%0d", tbl[i].line, tbl[i].ch),
            cnts[tbl[i].line][tbl[i].ch], tbl[i].exp);
    check("line after frame", int'(line), 0);

    // Scrambled ordering: same totals, gs=9 puts 2 highs in segment 0.
    mode = 1'b1;
    run_frame();
    mode = 1'b0;
    check_frame("mode1 frame", act);
`ifdef LEDDC_SCRAMBLE_EN
    check("mode1 seg0 spread", seg0_hits, 2);
`else
    check("mode1 seg0 spread", seg0_hits, 9);
`endif

    // Shadow rewrite mid-frame without swap stays invisible.
    clear_counts();
    Vsync = 1'b1;
    fork
      run_edges(FRAME);
      begin
        repeat (300) @(posedge GCK);
        #1;
        for (int i = 0; i < 16; i++) put(tbl[i].line, tbl[i].ch, tbl[i].gs ^ 8'h5A);
      end
    join
    Vsync = 1'b0;
    check_frame("shadow write frame", act);
    run_frame();
    check_frame("shadow write next", act);
    pulse_swap();
    check("swap_pend set 2", int'(swap_pend), 1);
    // A write on the edge where the swap applies lands in the new active bank.
    clear_counts();
    Vsync = 1'b1;
    run_edges(FRAME - 1);
    wr_en = 1'b1; wr_line = 0; wr_ch = 3; wr_data = 8'h33;
    mdl[1-act][0][3] = 8'h33;
    run_edges(1);
    wr_en = 1'b0;
    Vsync = 1'b0;
    check_frame("frame before swap", act);
    check("swap_pend cleared 2", int'(swap_pend), 0);
    act = 1 - act;
    run_frame();
    check_frame("post-swap frame", act);
    check("swap-edge write", cnts[0][3], 8'h33);

    // Vsync drop 16 cycles into line 2, then a full restart of line 2.
    clear_counts();
    Vsync = 1'b1;
    run_edges(2 * PERIOD + 16);
    Vsync = 1'b0;
    @(posedge GCK); #1;
    check("vsync drop OUT", int'(OUT), 0);
    check("vsync drop line", int'(line), 2);
    repeat (5) @(posedge GCK);
    #1;
    clear_counts();
    Vsync = 1'b1;
    run_edges(PERIOD);
    for (int c = 0; c < CH; c++)
      check($sformatf("restart line2 c%0d", c), cnts[2][c], mdl[act][2][c]);
    check("line after restart", int'(line), 3);
    run_edges(PERIOD);
    Vsync = 1'b0;
    check("line wrap after restart", int'(line), 0);

    // Async reset in the middle of a cycle.
    Vsync = 1'b1;
    run_edges(100);
    pulse_swap();
    check("swap_pend before reset", int'(swap_pend), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async reset OUT", int'(OUT), 0);
    check("async reset line", int'(line), 0);
    check("async reset swap_pend", int'(swap_pend), 0);
    Vsync = 1'b0;
    @(negedge GCK);
    rst_n = 1'b1;
    @(posedge GCK); #1;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < SCAN; l++)
        for (int c = 0; c < CH; c++) mdl[b][l][c] = 0;
    act = 0;
    run_frame();
    check_frame("after reset frame", 0);

    // Swap plus write on the wrap edge: swap deferred by one frame.
    put(1, 1, 8'h22);
    put(3, 2, 8'h90);
    clear_counts();
    Vsync = 1'b1;
    run_edges(FRAME - 1);
    swap = 1'b1;
    wr_en = 1'b1; wr_line = 0; wr_ch = 0; wr_data = 8'hA5;
    mdl[1-act][0][0] = 8'hA5;
    run_edges(1);
    swap = 1'b0; wr_en = 1'b0;
    Vsync = 1'b0;
    check("boundary swap pending", int'(swap_pend), 1);
    check("boundary frame_done", fd_cnt, 1);
    check_frame("boundary frame", act);
    run_frame();
    check_frame("deferred frame", act);
    check("deferred swap applied", int'(swap_pend), 0);
    act = 1 - act;
    run_frame();
    check_frame("deferred new frame", act);
    check("boundary write visible", cnts[0][0], 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
